// File: rtl/jpeg_dct_feeder.sv
// Buffers one 8x8 block from the DMA and replays it to the DCT as eight level-shifted rows.
// Each row takes 3 cycles (READ_LO, READ_HI, EMIT); EMIT holds row_o stable until row_ready_i.
module jpeg_dct_feeder #(
  parameter int BLK_WORDS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dma_bram_data,
  input  logic [8:0]  dma_bram_addr,
  input  logic        dma_bram_we,
  input  logic        start_dct,
  output logic        dct_busy,
  output logic [63:0] row_o,
  output logic [2:0]  row_idx_o,
  output logic        row_last_o,
  output logic        row_valid_o,
  input  logic        row_ready_i,
  output logic        overrun_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ_LO = 2'd1;
  localparam logic [1:0] ST_READ_HI = 2'd2;
  localparam logic [1:0] ST_EMIT    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  row_q;
  logic [31:0] buf_mem [BLK_WORDS];
  logic [31:0] rd_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        ovr_q;
  logic        rd_en;
  logic        hshake;
  logic [3:0]  rd_addr;
  logic [3:0]  wr_addr;
  logic        unused_addr_hi;

  assign wr_addr        = dma_bram_addr[3:0];
  assign unused_addr_hi = ^dma_bram_addr[8:4];
  assign rd_en          = (state_q == ST_READ_LO) || (state_q == ST_READ_HI);
  assign rd_addr        = {row_q, (state_q == ST_READ_HI)};
  assign hshake         = (state_q == ST_EMIT) && row_ready_i;

  // Unreset storage with an enabled read register so it maps onto block RAM;
  // rd_q keeps the high word for the whole of EMIT because reads stop there.
  always_ff @(posedge clk_i) begin
    if (dma_bram_we) begin
      buf_mem[wr_addr] <= dma_bram_data;
    end
    if (rd_en) begin
      rd_q <= buf_mem[rd_addr];
    end
    if (state_q == ST_READ_HI) begin
      lo_q <= rd_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_dct) state_d = ST_READ_LO;
      ST_READ_LO: state_d = ST_READ_HI;
      ST_READ_HI: state_d = ST_EMIT;
      ST_EMIT:    if (row_ready_i) state_d = (row_q == 3'd7) ? ST_IDLE : ST_READ_LO;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      if ((state_q == ST_IDLE) && start_dct) begin
        row_q <= '0;
      end else if (hshake) begin
        row_q <= row_q + 3'd1;
      end
      if (busy_q && (start_dct || dma_bram_we)) begin
        ovr_q <= 1'b1;
      end
    end
  end

  // XOR with 0x80 per byte is the unsigned-to-signed shift (pixel - 128).
  assign row_valid_o = (state_q == ST_EMIT);
  assign row_o       = row_valid_o ? {lo_q ^ 32'h8080_8080, rd_q ^ 32'h8080_8080} : 64'd0;
  assign row_idx_o   = row_q;
  assign row_last_o  = row_valid_o && (row_q == 3'd7);
  assign dct_busy    = busy_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_jpeg_dct_feeder.sv
// Randomised and directed bench for jpeg_dct_feeder against a cycle-level behavioural model.
module tb_jpeg_dct_feeder;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] dma_bram_data;
  logic [8:0]  dma_bram_addr;
  logic        dma_bram_we;
  logic        start_dct;
  logic        dct_busy;
  logic [63:0] row_o;
  logic [2:0]  row_idx_o;
  logic        row_last_o;
  logic        row_valid_o;
  logic        row_ready_i;
  logic        overrun_o;

  jpeg_dct_feeder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dma_bram_data(dma_bram_data), .dma_bram_addr(dma_bram_addr), .dma_bram_we(dma_bram_we),
    .start_dct(start_dct), .dct_busy(dct_busy),
    .row_o(row_o), .row_idx_o(row_idx_o), .row_last_o(row_last_o),
    .row_valid_o(row_valid_o), .row_ready_i(row_ready_i), .overrun_o(overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Model: what the block must present, derived from the buffer contents and row timing rules.
  logic [31:0] model_mem [16];
  bit          m_busy = 0;
  int          m_gap = 0;
  int          m_row = 0;
  bit          m_ovr = 0;

  logic [63:0] obs_rows [8];
  int          hs_count = 0;
  int          last_count = 0;
  int          busy_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_row(input int r);
    return {model_mem[2*r] ^ 32'h8080_8080, model_mem[2*r+1] ^ 32'h8080_8080};
  endfunction

  always @(negedge clk_i) begin
    bit exp_vld;
    exp_vld = m_busy && (m_gap == 0);
    check("busy", 64'(dct_busy), 64'(m_busy));
    check("valid", 64'(row_valid_o), 64'(exp_vld));
    check("overrun", 64'(overrun_o), 64'(m_ovr));
    if (exp_vld) begin
      check("row_data", row_o, model_row(m_row));
      check("row_idx", 64'(row_idx_o), 64'(m_row));
      check("row_last", 64'(row_last_o), 64'(m_row == 7));
    end else begin
      check("row_last_idle", 64'(row_last_o), 64'd0);
    end
    if (dct_busy === 1'b1) busy_cycles++;
    if (row_valid_o === 1'b1 && row_ready_i === 1'b1) begin
      obs_rows[row_idx_o] = row_o;
      hs_count++;
      if (row_last_o === 1'b1) last_count++;
    end
    // advance the model to the state after the coming rising edge
    if (rst_i) begin
      m_busy = 0; m_gap = 0; m_row = 0; m_ovr = 0;
    end else begin
      if (m_busy && (start_dct || dma_bram_we)) m_ovr = 1;
      if (m_busy) begin
        if (m_gap > 0) m_gap--;
        else if (row_ready_i) begin
          if (m_row == 7) m_busy = 0;
          else begin m_row++; m_gap = 2; end
        end
      end else if (start_dct) begin
        m_busy = 1; m_gap = 2; m_row = 0;
      end
    end
    if (dma_bram_we) model_mem[dma_bram_addr[3:0]] = dma_bram_data;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    dma_bram_we = 1'b1; dma_bram_addr = a; dma_bram_data = d;
    tick();
    dma_bram_we = 1'b0;
  endtask

  task automatic pulse_start();
    start_dct = 1'b1;
    tick();
    start_dct = 1'b0;
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  task automatic wait_valid_idx(input logic [2:0] k);
    for (int n = 0; n < 200; n++) begin
      if (row_valid_o === 1'b1 && row_idx_o === k) return;
      tick();
    end
    timeout("wait_valid_idx");
  endtask

  task automatic wait_idle(input bit rand_rdy);
    for (int n = 0; n < 400; n++) begin
      if (dct_busy === 1'b0) return;
      if (rand_rdy) row_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    timeout("wait_idle");
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) wr({5'($urandom_range(0, 31)), 4'(i)}, $urandom);
  endtask

  initial begin
    int n;
    rst_i = 1'b1; dma_bram_data = '0; dma_bram_addr = '0; dma_bram_we = 1'b0;
    start_dct = 1'b0; row_ready_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    check("rst_busy", 64'(dct_busy), 64'd0);
    check("rst_valid", 64'(row_valid_o), 64'd0);
    check("rst_last", 64'(row_last_o), 64'd0);
    check("rst_idx", 64'(row_idx_o), 64'd0);
    check("rst_row", row_o, 64'd0);
    check("rst_overrun", 64'(overrun_o), 64'd0);

    // ramp pattern
    for (int i = 0; i < 16; i++)
      wr(9'(i), {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
    row_ready_i = 1'b1; busy_cycles = 0; hs_count = 0; last_count = 0;
    pulse_start();
    n = 1;
    while (row_valid_o !== 1'b1 && n < 10) begin tick(); n++; end
    check("first_valid_latency", 64'(n), 64'd3);
    wait_idle(0);
    check("ramp_row0", obs_rows[0], 64'h80818283_84858687);
    check("ramp_row7", obs_rows[7], 64'hB8B9BABB_BCBDBEBF);
    check("ramp_busy_cycles", 64'(busy_cycles), 64'd24);
    check("ramp_rows", 64'(hs_count), 64'd8);
    check("ramp_last_count", 64'(last_count), 64'd1);

    // level-shift extremes
    for (int i = 0; i < 16; i++) wr(9'(i), 32'h00FF807F);
    hs_count = 0;
    pulse_start();
    wait_idle(0);
    for (int r = 0; r < 8; r++) check("extreme_row", obs_rows[r], 64'h807F00FF_807F00FF);

    // backpressure on row 3
    load_random();
    busy_cycles = 0; hs_count = 0;
    pulse_start();
    wait_valid_idx(3);
    row_ready_i = 1'b0;
    repeat (5) tick();
    row_ready_i = 1'b1;
    wait_idle(0);
    check("bp_busy_cycles", 64'(busy_cycles), 64'd29);
    check("bp_rows", 64'(hs_count), 64'd8);

    // start_dct while busy
    load_random();
    hs_count = 0;
    pulse_start();
    wait_valid_idx(2);
    pulse_start();
    wait_idle(0);
    check("proto_rows", 64'(hs_count), 64'd8);
    check("proto_overrun", 64'(overrun_o), 64'd1);

    // address wrap: 9'h013 lands in index 3
    for (int i = 0; i < 16; i++) if (i != 3) wr(9'(i), $urandom);
    wr(9'h013, 32'hDEADBEEF);
    pulse_start();
    wait_idle(0);
    check("wrap_row1_hi", {32'd0, obs_rows[1][31:0]}, 64'h5E2D3E6F);
    check("overrun_sticky", 64'(overrun_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("overrun_cleared", 64'(overrun_o), 64'd0);

    // back-to-back blocks, then reset mid-emission
    load_random();
    pulse_start();
    wait_valid_idx(7);
    tick();
    pulse_start();
    check("b2b_accepted", 64'(dct_busy), 64'd1);
    wait_valid_idx(4);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort_valid", 64'(row_valid_o), 64'd0);
    check("abort_busy", 64'(dct_busy), 64'd0);
    hs_count = 0;
    repeat (30) tick();
    check("abort_no_rows", 64'(hs_count), 64'd0);
    check("b2b_no_overrun", 64'(overrun_o), 64'd0);

    // random blocks with random backpressure and idle gaps
    for (int b = 0; b < 6; b++) begin
      load_random();
      repeat ($urandom_range(0, 3)) tick();
      hs_count = 0;
      pulse_start();
      wait_idle(1);
      row_ready_i = 1'b1;
      check("rand_rows", 64'(hs_count), 64'd8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
